// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares the single-port BootROM macro between NREQ requesters.
// Round-robin grant, one read in flight, byte address -> word index. Misaligned or
// out-of-window addresses get an error response and never enable the ROM.

// Per-requester address decode: ROM word index plus bounds/alignment error.
module bootrom_addr_chk #(
    parameter int ROM_AW = 11,
    parameter int ADDR_W = 13
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ROM_AW-1:0] word,
    output logic              err
);
    logic hi_err;

    assign word = addr[ROM_AW+1:2];

    generate
        if (ADDR_W > ROM_AW + 2) begin : g_hi
            // Any bit set above the ROM window lands past the last word.
            assign hi_err = |addr[ADDR_W-1:ROM_AW+2];
        end else begin : g_nohi
            assign hi_err = 1'b0;
        end
    endgenerate

    assign err = (addr[1:0] != 2'b00) || hi_err;
endmodule

module bootrom_arbiter #(
    parameter int NREQ   = 2,
    parameter int ROM_AW = 11,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_err,
    output logic                   rom_me,
    output logic                   rom_oe,
    output logic [ROM_AW-1:0]      rom_address,
    input  logic [DATA_W-1:0]      rom_q
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               owner_q, owner_d;
    logic [IW-1:0]               prio_q, prio_d;
    logic                        err_q, err_d;
    logic [IW-1:0]               gnt;
    logic                        gnt_any;
    logic [NREQ-1:0][ROM_AW-1:0] word;
    logic [NREQ-1:0]             addr_err;
    logic                        resp_fire;
    logic                        accept;

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_req
            bootrom_addr_chk #(
                .ROM_AW (ROM_AW),
                .ADDR_W (ADDR_W)
            ) u_chk (
                .addr (req_addr[i*ADDR_W +: ADDR_W]),
                .word (word[i]),
                .err  (addr_err[i])
            );
        end
    endgenerate

    // Round-robin pick: first valid requester at or after prio, wrapping mod NREQ.
    always_comb begin
        logic [IW:0] sum;
        gnt     = '0;
        gnt_any = 1'b0;
        sum     = '0;
        // Scan downwards so the lowest offset from prio is the one left standing.
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, prio_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
            if (req_valid[sum[IW-1:0]]) begin
                gnt     = sum[IW-1:0];
                gnt_any = 1'b1;
            end
        end
    end

    // State, owner, error flag and priority pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            err_q   <= 1'b0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
        end
    end

    // Next state and all outputs; reset forces every output quiet combinationally.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        err_d       = err_q;
        prio_d      = prio_q;
        req_ready   = '0;
        resp_valid  = '0;
        resp_data   = '0;
        resp_err    = 1'b0;
        rom_me      = 1'b0;
        rom_oe      = 1'b0;
        rom_address = '0;
        resp_fire   = 1'b0;
        accept      = 1'b0;
        if (!reset) begin
            if (state_q == RESP) begin
                resp_valid[owner_q] = 1'b1;
                resp_err            = err_q;
                // rom_q is only looked at while the macro drives it.
                rom_oe              = !err_q;
                if (!err_q) resp_data = rom_q;
                resp_fire           = resp_ready[owner_q];
            end
            // A new read may start only once the current data has been taken;
            // the ROM output register then updates at the same edge.
            accept = gnt_any && ((state_q == IDLE) || resp_fire);
            if (accept) begin
                req_ready[gnt] = 1'b1;
                rom_me         = !addr_err[gnt];
                rom_address    = word[gnt];
                state_d        = RESP;
                owner_d        = gnt;
                err_d          = addr_err[gnt];
                prio_d         = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end else if (resp_fire) begin
                state_d = IDLE;
            end
        end
    end

    // At most one requester is accepted and at most one response is offered.
    a_ready_1hot : assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));
    a_resp_1hot  : assert property (@(posedge clock) disable iff (reset) $onehot0(resp_valid));
endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter: directed and random scoreboard bench for bootrom_arbiter
// (NREQ=3, 14-bit byte addresses so out-of-window addresses are reachable).
module tb_bootrom_arbiter;
    localparam int NREQ   = 3;
    localparam int ROM_AW = 11;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ-1:0]        resp_ready;
    logic [DATA_W-1:0]      resp_data;
    logic                   resp_err;
    logic                   rom_me;
    logic                   rom_oe;
    logic [ROM_AW-1:0]      rom_address;
    logic [DATA_W-1:0]      rom_q;

    bootrom_arbiter #(
        .NREQ   (NREQ),
        .ROM_AW (ROM_AW),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .rom_me      (rom_me),
        .rom_oe      (rom_oe),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    always #5 clock = ~clock;

    // ROM contents: odd multiplier keeps every word distinct and nonzero at 0.
    function automatic logic [31:0] romw(input logic [ROM_AW-1:0] w);
        logic [31:0] x;
        x = {21'b0, w};
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    // Macro model: registered output, updated only on me, garbage when oe is low.
    logic [31:0] rom_reg;
    always @(posedge clock) if (rom_me) rom_reg <= romw(rom_address);
    assign rom_q = rom_oe ? rom_reg : 32'hDEAD_BEEF;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t            sbq[$];
    int              n_vec = 0;
    int              n_miss = 0;
    logic [NREQ-1:0] acc_mask = '0;
    int              waitc[NREQ];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic seta(input int i, input logic [ADDR_W-1:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return ADDR_W'($urandom_range(0, 16383));
        return {1'b0, 11'($urandom_range(0, 2047)), 2'b00};
    endfunction

    // Scoreboard monitor: pops/compares responses, pushes accepted requests.
    task automatic mon();
        exp_t              e;
        logic [ADDR_W-1:0] a;
        logic              aerr;
        int                g;
        if (reset) begin
            sbq.delete();
            acc_mask = '0;
            for (int i = 0; i < NREQ; i++) waitc[i] = 0;
            return;
        end
        chk("rdy_1hot", 64'($countones(req_ready) <= 1), 64'd1);
        if (sbq.size() == 0) begin
            chk("rsp_spur", 64'(resp_valid), 64'd0);
        end else begin
            e = sbq[0];
            chk("rsp_owner", 64'(resp_valid), 64'd1 << e.id);
            chk("rsp_data", 64'(resp_data), 64'(e.data));
            chk("rsp_err", 64'(resp_err), 64'(e.err));
            if ((resp_valid & resp_ready) != '0) void'(sbq.pop_front());
        end
        acc_mask = req_valid & req_ready;
        g = -1;
        for (int i = 0; i < NREQ; i++) if (acc_mask[i]) g = i;
        if (g >= 0) begin
            a    = req_addr[g*ADDR_W +: ADDR_W];
            aerr = (a[1:0] != 2'b00) || (a >= 14'h2000);
            chk("me_acc", 64'(rom_me), 64'(!aerr));
            if (!aerr) chk("rom_addr", 64'(rom_address), 64'(a[12:2]));
            e.id   = g;
            e.err  = aerr;
            e.data = aerr ? 32'h0 : romw(a[12:2]);
            sbq.push_back(e);
        end else begin
            chk("me_idle", 64'(rom_me), 64'd0);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (i == g || !req_valid[i]) begin
                waitc[i] = 0;
            end else if (g >= 0) begin
                waitc[i]++;
                chk("starve", 64'(waitc[i] < NREQ), 64'd1);
            end
        end
    endtask

    initial forever begin
        @(negedge clock);
        mon();
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        reset = 1'b1; req_valid = '0; resp_ready = '0; req_addr = '0;
        tick();
        // Reset keeps everything quiet even with a request present.
        req_valid = 3'b001; seta(0, 14'h0004); resp_ready = '1;
        smp();
        chk("rst_rdy", 64'(req_ready), 64'd0);
        chk("rst_rsp", 64'(resp_valid), 64'd0);
        chk("rst_me", 64'(rom_me), 64'd0);
        chk("rst_oe", 64'(rom_oe), 64'd0);
        chk("rst_addr", 64'(rom_address), 64'd0);
        chk("rst_data", 64'(resp_data), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);

        // Single read of word 1.
        tick(); reset = 1'b0;
        smp();
        chk("t1_rdy", 64'(req_ready), 64'd1);
        chk("t1_me", 64'(rom_me), 64'd1);
        chk("t1_addr", 64'(rom_address), 64'd1);
        tick(); req_valid = '0;
        smp();
        chk("t1_rsp", 64'(resp_valid), 64'd1);
        chk("t1_data", 64'(resp_data), 64'(romw(11'd1)));
        chk("t1_err", 64'(resp_err), 64'd0);
        chk("t1_oe", 64'(rom_oe), 64'd1);
        tick();
        smp();
        chk("t1_idle", 64'(resp_valid), 64'd0);
        chk("t1_idle_oe", 64'(rom_oe), 64'd0);
        chk("t1_idle_data", 64'(resp_data), 64'd0);

        // Round-robin between 0 and 1; prio points at 1 after the first read.
        tick(); req_valid = 3'b011; seta(0, 14'h0010); seta(1, 14'h0020); resp_ready = '1;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rr_gnt", 64'(req_ready), (k % 2 == 0) ? 64'd2 : 64'd1);
            if (k > 0) chk("rr_rsp", 64'(resp_valid), (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            seta(0, ADDR_W'((k + 1) * 16)); seta(1, ADDR_W'((k + 1) * 16 + 4));
        end
        req_valid = '0;
        smp();
        tick();

        // Backpressure on the last word; requester 0 waits behind it.
        req_valid = 3'b010; seta(1, 14'h1FFC);
        smp();
        chk("t3_rdy", 64'(req_ready), 64'd2);
        chk("t3_me", 64'(rom_me), 64'd1);
        chk("t3_addr", 64'(rom_address), 64'd2047);
        tick(); req_valid = 3'b001; seta(0, 14'h0008); resp_ready = 3'b101;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("t3_stall_rsp", 64'(resp_valid), 64'd2);
            chk("t3_stall_data", 64'(resp_data), 64'(romw(11'd2047)));
            chk("t3_stall_me", 64'(rom_me), 64'd0);
            chk("t3_stall_rdy", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = '1;
        smp();
        chk("t3_fire", 64'(resp_valid), 64'd2);
        chk("t3_fire_data", 64'(resp_data), 64'(romw(11'd2047)));
        chk("t3_regrant", 64'(req_ready), 64'd1);
        chk("t3_me2", 64'(rom_me), 64'd1);
        chk("t3_addr2", 64'(rom_address), 64'd2);
        tick(); req_valid = '0;
        smp();
        chk("t3_rsp0", 64'(resp_valid), 64'd1);
        chk("t3_data0", 64'(resp_data), 64'(romw(11'd2)));
        tick();

        // Misaligned and out-of-window addresses.
        req_valid = 3'b001; seta(0, 14'h0006);
        smp();
        chk("t4_rdy", 64'(req_ready), 64'd1);
        chk("t4_me", 64'(rom_me), 64'd0);
        tick(); req_valid = 3'b100; seta(2, 14'h2000);
        smp();
        chk("t4_rsp", 64'(resp_valid), 64'd1);
        chk("t4_err", 64'(resp_err), 64'd1);
        chk("t4_data", 64'(resp_data), 64'd0);
        chk("t4_oe", 64'(rom_oe), 64'd0);
        chk("t4_rdy2", 64'(req_ready), 64'd4);
        chk("t4_me2", 64'(rom_me), 64'd0);
        tick(); req_valid = '0;
        smp();
        chk("t4_rsp2", 64'(resp_valid), 64'd4);
        chk("t4_err2", 64'(resp_err), 64'd1);
        chk("t4_data2", 64'(resp_data), 64'd0);
        chk("t4_me3", 64'(rom_me), 64'd0);
        tick();

        // Reset while a response to requester 0 is stalled.
        req_valid = 3'b001; seta(0, 14'h000C); resp_ready = '0;
        smp();
        chk("t5_rdy", 64'(req_ready), 64'd1);
        tick(); req_valid = '0;
        smp();
        chk("t5_stall", 64'(resp_valid), 64'd1);
        tick(); reset = 1'b1;
        smp();
        chk("t5_rst_rsp", 64'(resp_valid), 64'd0);
        chk("t5_rst_oe", 64'(rom_oe), 64'd0);
        chk("t5_rst_data", 64'(resp_data), 64'd0);
        chk("t5_rst_err", 64'(resp_err), 64'd0);
        tick(); reset = 1'b0; req_valid = 3'b101; seta(0, 14'h0014); seta(2, 14'h0018); resp_ready = '1;
        smp();
        chk("t5_idle", 64'(resp_valid), 64'd0);
        chk("t5_prio", 64'(req_ready), 64'd1);
        tick(); req_valid = 3'b010; seta(1, 14'h0040);
        smp();
        chk("t5_rsp0", 64'(resp_valid), 64'd1);
        chk("t5_rdy1", 64'(req_ready), 64'd2);
        chk("t5_addr1", 64'(rom_address), 64'd16);
        tick(); req_valid = '0;
        smp();
        chk("t5_rsp1", 64'(resp_valid), 64'd2);
        chk("t5_data1", 64'(resp_data), 64'(romw(11'd16)));
        chk("t5_err1", 64'(resp_err), 64'd0);
        tick();

        // Random traffic; requesters hold valid until accepted.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req_valid[i] = 1'b1;
                        seta(i, rnd_addr());
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            smp();
            tick();
        end
        req_valid = '0; resp_ready = '1;
        repeat (3) begin
            smp();
            tick();
        end
        smp();
        chk("drain", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
